stream_pair_aligner: RTL

//  Downstream consumer of two file-reader stimulus streams (operand A, operand B).

---
 rtl/stream_pair_aligner_pkg.sv | 11 +
 rtl/stream_pair_aligner_fifo.sv | 50 +++++
 rtl/stream_pair_aligner.sv | 105 ++++++++++
 3 files changed

// File: rtl/stream_pair_aligner_pkg.sv
// Shared types and defaults for the A/B operand pair aligner.
package stream_pair_aligner_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/stream_pair_aligner_fifo.sv
// Small synchronous FIFO with occupancy output; same-cycle push and pop are legal.
module sync_fifo #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  head,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign level = r_count;
  assign full  = (r_count == FULL_LVL);
  assign empty = (r_count == '0);

endmodule

// File: rtl/stream_pair_aligner.sv
// Buffers two stb/ack operand streams and emits matched {A,B} pairs in arrival order.
module stream_pair_aligner
  import stream_pair_aligner_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  input_a,
  input  logic              input_a_stb,
  output logic              input_a_ack,
  input  logic [WIDTH-1:0]  input_b,
  input  logic              input_b_stb,
  output logic              input_b_ack,
  output logic [WIDTH-1:0]  output_a,
  output logic [WIDTH-1:0]  output_b,
  output logic              output_stb,
  input  logic              output_ack,
  output logic [ADDR_W:0]   level_a,
  output logic [ADDR_W:0]   level_b,
  output logic [31:0]       pair_count
);

  state_t           r_state;
  logic             r_ack_a;
  logic             r_ack_b;
  logic [WIDTH-1:0] r_out_a;
  logic [WIDTH-1:0] r_out_b;
  logic             r_out_stb;
  logic [31:0]      r_pair_count;

  logic             w_push_a;
  logic             w_push_b;
  logic             w_pop;
  logic [WIDTH-1:0] w_head_a;
  logic [WIDTH-1:0] w_head_b;
  logic             w_full_a;
  logic             w_full_b;
  logic             w_empty_a;
  logic             w_empty_b;

  assign w_push_a = input_a_stb & r_ack_a;
  assign w_push_b = input_b_stb & r_ack_b;
  assign w_pop    = (r_state == PRESENT) & r_out_stb & output_ack;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo_a (
    .clk(clk), .rst(rst), .push(w_push_a), .push_data(input_a), .pop(w_pop),
    .head(w_head_a), .level(level_a), .full(w_full_a), .empty(w_empty_a)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo_b (
    .clk(clk), .rst(rst), .push(w_push_b), .push_data(input_b), .pop(w_pop),
    .head(w_head_b), .level(level_b), .full(w_full_b), .empty(w_empty_b)
  );

  // Ack is a single-cycle pulse, so each reader gets at most one word per two cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
    end else begin
      r_ack_a <= input_a_stb & ~r_ack_a & ~w_full_a;
      r_ack_b <= input_b_stb & ~r_ack_b & ~w_full_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_out_a      <= '0;
      r_out_b      <= '0;
      r_out_stb    <= 1'b0;
      r_pair_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty_a && !w_empty_b) begin
            r_out_a   <= w_head_a;
            r_out_b   <= w_head_b;
            r_out_stb <= 1'b1;
            r_state   <= PRESENT;
          end
        end
        PRESENT: begin
          if (w_pop) begin
            r_out_stb    <= 1'b0;
            r_pair_count <= r_pair_count + 32'd1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign input_a_ack = r_ack_a;
  assign input_b_ack = r_ack_b;
  assign output_a    = r_out_a;
  assign output_b    = r_out_b;
  assign output_stb  = r_out_stb;
  assign pair_count  = r_pair_count;

endmodule
